// File: rtl/fsm_calculator_seq.sv
// Multi-digit keypad calculator: decimal entry, + - * / with left-to-right
// chaining, repeated '=', error reporting and a sequential restoring divider.
module fsm_calculator_seq #(
   parameter int WIDTH      = 16,
   parameter int MAX_DIGITS = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [7:0]       button,
   output logic [WIDTH-1:0] display,
   output logic [WIDTH-1:0] result,
   output logic [2:0]       op_pending,
   output logic             busy,
   output logic             error,
   output logic [1:0]       err_code
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam int DIV_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_NONE = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_MUL  = 3'd3;
   localparam logic [2:0] OP_DIV  = 3'd4;

   localparam logic [7:0] KEY_EQ  = 8'h24;
   localparam logic [7:0] KEY_CLR = 8'h04;

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY_A, S_OP_WAIT, S_ENTRY_B, S_CALC, S_DIVIDE, S_SHOW, S_ERROR
   } state_t;

   // {valid, value} for a digit key
   function automatic logic [4:0] key_digit(input logic [7:0] k);
      logic [4:0] r;
      case (k)
         8'h14:   r = 5'h10;
         8'h05:   r = 5'h11;
         8'h15:   r = 5'h12;
         8'h25:   r = 5'h13;
         8'h06:   r = 5'h14;
         8'h16:   r = 5'h15;
         8'h26:   r = 5'h16;
         8'h07:   r = 5'h17;
         8'h17:   r = 5'h18;
         8'h27:   r = 5'h19;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   function automatic logic [2:0] key_op(input logic [7:0] k);
      logic [2:0] r;
      case (k)
         8'h37:   r = OP_ADD;
         8'h36:   r = OP_SUB;
         8'h35:   r = OP_MUL;
         8'h34:   r = OP_DIV;
         default: r = OP_NONE;
      endcase
      return r;
   endfunction

   // Appends a digit unless the entry is full or the value would not fit.
   function automatic logic [CNT_W+WIDTH-1:0] enter_digit(input logic [WIDTH-1:0] acc,
                                                          input logic [CNT_W-1:0] cnt,
                                                          input logic [3:0]       d);
      logic [WIDTH+3:0] wide;
      logic [WIDTH-1:0] acc_o;
      logic [CNT_W-1:0] cnt_o;
      wide  = {4'b0000, acc} * (WIDTH+4)'(10) + {{WIDTH{1'b0}}, d};
      acc_o = acc;
      cnt_o = cnt;
      if ((int'(cnt) < MAX_DIGITS) && (wide[WIDTH+3:WIDTH] == 4'b0000)) begin
         acc_o = wide[WIDTH-1:0];
         if (!((acc == '0) && (d == 4'd0)))
            cnt_o = cnt + 1'b1;
      end
      return {cnt_o, acc_o};
   endfunction

   // {err_code, value} for the single-cycle operators; OP_NONE passes x through.
   function automatic logic [WIDTH+1:0] alu(input logic [2:0]       op,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
      logic [WIDTH:0]     sum;
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH+1:0]   r;
      sum  = {1'b0, x} + {1'b0, y};
      prod = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
      r    = {2'd0, x};
      case (op)
         OP_ADD:  r = sum[WIDTH] ? {2'd2, sum[WIDTH-1:0]} : {2'd0, sum[WIDTH-1:0]};
         OP_SUB:  r = (x < y) ? {2'd3, {WIDTH{1'b0}}} : {2'd0, x - y};
         OP_MUL:  r = (prod[2*WIDTH-1:WIDTH] != '0) ? {2'd2, prod[WIDTH-1:0]}
                                                     : {2'd0, prod[WIDTH-1:0]};
         default: r = {2'd0, x};
      endcase
      return r;
   endfunction

   state_t           state, state_n, ret_r, ret_n;
   logic [7:0]       prev_button;
   logic [WIDTH-1:0] a_r, a_n, b_r, b_n, res_r, res_n, disp_r, disp_n;
   logic [WIDTH-1:0] rem_r, rem_n, quot_r, quot_n;
   logic [2:0]       op_r, op_n, pend_r, pend_n;
   logic [CNT_W-1:0] cnt_r, cnt_n;
   logic [DIV_W-1:0] dcnt_r, dcnt_n;
   logic [1:0]       err_r, err_n;

   logic             key_valid, is_digit, is_op, is_eq, is_clr;
   logic [4:0]       kd;
   logic [2:0]       kop;
   logic [WIDTH-1:0] d_ext;
   logic [CNT_W-1:0] first_cnt;
   logic [CNT_W+WIDTH-1:0] entry_a, entry_b;
   logic [WIDTH+1:0] alu_out;
   logic [WIDTH:0]   shifted, diff;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quot_step;

   assign key_valid = (button != prev_button) && (button != 8'h00);
   assign kd        = key_digit(button);
   assign kop       = key_op(button);
   assign is_digit  = key_valid && kd[4];
   assign is_op     = key_valid && (kop != OP_NONE);
   assign is_eq     = key_valid && (button == KEY_EQ);
   assign is_clr    = key_valid && (button == KEY_CLR);
   assign d_ext     = {{(WIDTH-4){1'b0}}, kd[3:0]};
   assign first_cnt = (kd[3:0] != 4'd0) ? CNT_W'(1) : '0;
   assign entry_a   = enter_digit(a_r, cnt_r, kd[3:0]);
   assign entry_b   = enter_digit(b_r, cnt_r, kd[3:0]);
   assign alu_out   = alu(op_r, a_r, b_r);

   // Restoring divider step: shift in the next dividend bit, subtract if it fits.
   assign shifted   = {rem_r, quot_r[WIDTH-1]};
   assign diff      = shifted - {1'b0, b_r};
   assign ge        = (shifted >= {1'b0, b_r});
   assign rem_step  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quot_step = {quot_r[WIDTH-2:0], ge};

   always_comb begin
      state_n = state;
      ret_n   = ret_r;
      a_n     = a_r;
      b_n     = b_r;
      res_n   = res_r;
      op_n    = op_r;
      pend_n  = pend_r;
      cnt_n   = cnt_r;
      err_n   = err_r;
      rem_n   = rem_r;
      quot_n  = quot_r;
      dcnt_n  = dcnt_r;

      case (state)
         S_IDLE: begin
            if (is_digit) begin
               a_n     = d_ext;
               cnt_n   = first_cnt;
               state_n = S_ENTRY_A;
            end
         end
         S_ENTRY_A: begin
            if (is_digit) begin
               {cnt_n, a_n} = entry_a;
            end else if (is_op) begin
               op_n    = kop;
               state_n = S_OP_WAIT;
            end else if (is_eq) begin
               res_n   = a_r;
               state_n = S_SHOW;
            end
         end
         S_OP_WAIT: begin
            if (is_op) begin
               op_n = kop;
            end else if (is_digit) begin
               b_n     = d_ext;
               cnt_n   = first_cnt;
               state_n = S_ENTRY_B;
            end
         end
         S_ENTRY_B: begin
            if (is_digit) begin
               {cnt_n, b_n} = entry_b;
            end else if (is_eq) begin
               ret_n   = S_SHOW;
               state_n = S_CALC;
            end else if (is_op) begin
               ret_n   = S_OP_WAIT;
               pend_n  = kop;
               state_n = S_CALC;
            end
         end
         S_CALC: begin
            if (op_r == OP_DIV) begin
               if (b_r == '0) begin
                  err_n   = 2'd1;
                  state_n = S_ERROR;
               end else begin
                  rem_n   = '0;
                  quot_n  = a_r;
                  dcnt_n  = '0;
                  state_n = S_DIVIDE;
               end
            end else if (alu_out[WIDTH+1:WIDTH] != 2'd0) begin
               err_n   = alu_out[WIDTH+1:WIDTH];
               state_n = S_ERROR;
            end else begin
               res_n   = alu_out[WIDTH-1:0];
               a_n     = alu_out[WIDTH-1:0];
               state_n = ret_r;
               if (ret_r == S_OP_WAIT)
                  op_n = pend_r;
            end
         end
         S_DIVIDE: begin
            rem_n  = rem_step;
            quot_n = quot_step;
            dcnt_n = dcnt_r + 1'b1;
            if (dcnt_r == DIV_W'(WIDTH - 1)) begin
               res_n   = quot_step;
               a_n     = quot_step;
               state_n = ret_r;
               if (ret_r == S_OP_WAIT)
                  op_n = pend_r;
            end
         end
         S_SHOW: begin
            if (is_eq) begin
               a_n     = res_r;
               ret_n   = S_SHOW;
               state_n = S_CALC;
            end else if (is_op) begin
               a_n     = res_r;
               op_n    = kop;
               state_n = S_OP_WAIT;
            end else if (is_digit) begin
               a_n     = d_ext;
               cnt_n   = first_cnt;
               b_n     = '0;
               op_n    = OP_NONE;
               state_n = S_ENTRY_A;
            end
         end
         default: ;
      endcase

      // CLR key overrides everything, including a running division and ERROR.
      if (is_clr) begin
         state_n = S_IDLE;
         ret_n   = S_IDLE;
         a_n     = '0;
         b_n     = '0;
         res_n   = '0;
         op_n    = OP_NONE;
         pend_n  = OP_NONE;
         cnt_n   = '0;
         err_n   = 2'd0;
         rem_n   = '0;
         quot_n  = '0;
         dcnt_n  = '0;
      end

      case (state_n)
         S_ENTRY_A, S_OP_WAIT: disp_n = a_n;
         S_ENTRY_B:            disp_n = b_n;
         S_SHOW:               disp_n = res_n;
         S_CALC, S_DIVIDE:     disp_n = disp_r;
         default:              disp_n = '0;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state       <= S_IDLE;
         ret_r       <= S_IDLE;
         prev_button <= 8'h00;
         a_r         <= '0;
         b_r         <= '0;
         res_r       <= '0;
         disp_r      <= '0;
         op_r        <= OP_NONE;
         pend_r      <= OP_NONE;
         cnt_r       <= '0;
         err_r       <= 2'd0;
         rem_r       <= '0;
         quot_r      <= '0;
         dcnt_r      <= '0;
      end else begin
         state       <= state_n;
         ret_r       <= ret_n;
         prev_button <= button;
         a_r         <= a_n;
         b_r         <= b_n;
         res_r       <= res_n;
         disp_r      <= disp_n;
         op_r        <= op_n;
         pend_r      <= pend_n;
         cnt_r       <= cnt_n;
         err_r       <= err_n;
         rem_r       <= rem_n;
         quot_r      <= quot_n;
         dcnt_r      <= dcnt_n;
      end
   end

   assign display    = disp_r;
   assign result     = res_r;
   assign op_pending = op_r;
   assign busy       = (state == S_DIVIDE);
   assign error      = (state == S_ERROR);
   assign err_code   = err_r;

endmodule

// File: tb/tb_fsm_calculator_seq.sv
// Scenario bench for fsm_calculator_seq: expected results are queued when '='
// is keyed and popped when the calculator delivers them.
module tb_fsm_calculator_seq;

   localparam int W = 16;

   localparam logic [7:0] K_ADD = 8'h37, K_SUB = 8'h36, K_MUL = 8'h35, K_DIV = 8'h34;
   localparam logic [7:0] K_EQ  = 8'h24, K_CLR = 8'h04;

   logic         clk = 1'b0;
   logic         clear;
   logic [7:0]   button;
   logic [W-1:0] display, result;
   logic [2:0]   op_pending;
   logic         busy, error;
   logic [1:0]   err_code;

   logic [7:0]   dig [10] = '{8'h14, 8'h05, 8'h15, 8'h25, 8'h06, 8'h16, 8'h26, 8'h07, 8'h17, 8'h27};

   int           n_cmp = 0;
   int           n_err = 0;
   int unsigned  exp_q[$];
   int unsigned  exp_v;
   int           bcnt;

   fsm_calculator_seq #(.WIDTH(W), .MAX_DIGITS(4)) dut (
      .clk(clk), .clear(clear), .button(button), .display(display), .result(result),
      .op_pending(op_pending), .busy(busy), .error(error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic press(input logic [7:0] k);
      @(negedge clk);
      button = k;
      @(negedge clk);
      button = 8'h00;
   endtask

   task automatic count_busy();
      bcnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         else if (bcnt > 0) break;
      end
   endtask

   task automatic test_reset();
      clear  = 1'b1;
      button = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++; if (display !== 16'd0) begin n_err++; $display("FAIL reset_display: got %0d exp 0", display); end
      n_cmp++; if (result !== 16'd0) begin n_err++; $display("FAIL reset_result: got %0d exp 0", result); end
      n_cmp++; if (op_pending !== 3'd0) begin n_err++; $display("FAIL reset_op: got %0d exp 0", op_pending); end
      n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || err_code !== 2'd0)
         begin n_err++; $display("FAIL reset_flags: got busy=%b error=%b code=%0d exp 0/0/0", busy, error, err_code); end
      clear = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add();
      press(dig[1]); press(dig[2]);
      n_cmp++; if (display !== 16'd12) begin n_err++; $display("FAIL add_entry_a: got %0d exp 12", display); end
      press(K_ADD);
      n_cmp++; if (op_pending !== 3'd1) begin n_err++; $display("FAIL add_op: got %0d exp 1", op_pending); end
      press(dig[3]); press(dig[4]);
      n_cmp++; if (display !== 16'd34) begin n_err++; $display("FAIL add_entry_b: got %0d exp 34", display); end
      press(K_EQ);
      exp_q.push_back(46);
      n_cmp++; if (result !== 16'd0) begin n_err++; $display("FAIL add_early: got %0d exp 0", result); end
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++; if (result !== W'(exp_v)) begin n_err++; $display("FAIL add_result: got %0d exp %0d", result, exp_v); end
      n_cmp++; if (display !== W'(exp_v)) begin n_err++; $display("FAIL add_show: got %0d exp %0d", display, exp_v); end
   endtask

   task automatic test_div();
      press(K_CLR);
      press(dig[1]); press(dig[0]); press(dig[0]); press(K_DIV); press(dig[7]); press(K_EQ);
      exp_q.push_back(14);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL div_calc_busy: got %b exp 0", busy); end
      count_busy();
      n_cmp++; if (bcnt != W) begin n_err++; $display("FAIL div_busy_cycles: got %0d exp %0d", bcnt, W); end
      exp_v = exp_q.pop_front();
      n_cmp++; if (result !== W'(exp_v) || busy !== 1'b0)
         begin n_err++; $display("FAIL div_result: got %0d busy=%b exp %0d busy=0", result, busy, exp_v); end
   endtask

   task automatic test_div_zero();
      press(K_CLR);
      press(dig[5]); press(K_DIV); press(dig[0]); press(K_EQ);
      @(negedge clk);
      n_cmp++; if (error !== 1'b1 || err_code !== 2'd1 || display !== 16'd0)
         begin n_err++; $display("FAIL div0_error: got err=%b code=%0d disp=%0d exp 1/1/0", error, err_code, display); end
      press(dig[3]);
      n_cmp++; if (error !== 1'b1 || display !== 16'd0)
         begin n_err++; $display("FAIL div0_sticky: got err=%b disp=%0d exp 1/0", error, display); end
      press(K_CLR);
      n_cmp++; if (error !== 1'b0 || err_code !== 2'd0 || display !== 16'd0 || result !== 16'd0 || op_pending !== 3'd0)
         begin n_err++; $display("FAIL div0_clr: got err=%b code=%0d disp=%0d res=%0d op=%0d exp all 0",
                                 error, err_code, display, result, op_pending); end
      press(dig[6]);
      n_cmp++; if (display !== 16'd6) begin n_err++; $display("FAIL div0_after_clr: got %0d exp 6", display); end
   endtask

   task automatic test_overflow();
      press(K_CLR);
      press(dig[3]); press(dig[0]); press(dig[0]); press(K_MUL);
      press(dig[3]); press(dig[0]); press(dig[0]); press(K_EQ);
      @(negedge clk);
      n_cmp++; if (error !== 1'b1 || err_code !== 2'd2)
         begin n_err++; $display("FAIL mul_ovf: got err=%b code=%0d exp 1/2", error, err_code); end
      press(K_CLR);
      press(dig[3]); press(K_SUB); press(dig[5]); press(K_EQ);
      @(negedge clk);
      n_cmp++; if (error !== 1'b1 || err_code !== 2'd3)
         begin n_err++; $display("FAIL sub_neg: got err=%b code=%0d exp 1/3", error, err_code); end
      // 9999*6 = 59994, then +9999 carries out of 16 bits
      press(K_CLR);
      for (int i = 0; i < 4; i++) press(dig[9]);
      press(K_MUL); press(dig[6]); press(K_ADD);
      @(negedge clk);
      n_cmp++; if (display !== 16'd59994 || op_pending !== 3'd1)
         begin n_err++; $display("FAIL add_chain_a: got disp=%0d op=%0d exp 59994/1", display, op_pending); end
      for (int i = 0; i < 4; i++) press(dig[9]);
      press(K_EQ);
      @(negedge clk);
      n_cmp++; if (error !== 1'b1 || err_code !== 2'd2)
         begin n_err++; $display("FAIL add_carry: got err=%b code=%0d exp 1/2", error, err_code); end
   endtask

   task automatic test_chain();
      press(K_CLR);
      press(dig[2]); press(K_ADD); press(dig[3]); press(K_MUL);
      @(negedge clk);
      n_cmp++; if (display !== 16'd5 || op_pending !== 3'd3)
         begin n_err++; $display("FAIL chain_a: got disp=%0d op=%0d exp 5/3", display, op_pending); end
      press(dig[4]); press(K_EQ);
      exp_q.push_back(20);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++; if (result !== W'(exp_v)) begin n_err++; $display("FAIL chain_result: got %0d exp %0d", result, exp_v); end
      press(K_EQ);
      exp_q.push_back(80);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      n_cmp++; if (result !== W'(exp_v)) begin n_err++; $display("FAIL chain_repeat: got %0d exp %0d", result, exp_v); end
   endtask

   task automatic test_keys();
      press(K_CLR);
      @(negedge clk);
      button = dig[7];
      repeat (5) @(negedge clk);
      button = 8'h00;
      @(negedge clk);
      n_cmp++; if (display !== 16'd7) begin n_err++; $display("FAIL key_held: got %0d exp 7", display); end
      press(8'h99);
      n_cmp++; if (display !== 16'd7) begin n_err++; $display("FAIL key_unlisted: got %0d exp 7", display); end
      press(K_CLR);
      press(dig[0]); press(dig[0]);
      for (int i = 1; i <= 5; i++) press(dig[i]);
      n_cmp++; if (display !== 16'd1234) begin n_err++; $display("FAIL key_max_digits: got %0d exp 1234", display); end
   endtask

   task automatic test_back_to_back();
      press(K_CLR);
      press(dig[9]); press(dig[0]); press(dig[0]); press(dig[0]); press(K_DIV); press(dig[3]); press(K_EQ);
      exp_q.push_back(3000);
      press(dig[5]);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b exp 1", busy); end
      count_busy();
      exp_v = exp_q.pop_front();
      n_cmp++; if (result !== W'(exp_v) || display !== W'(exp_v))
         begin n_err++; $display("FAIL b2b_first: got res=%0d disp=%0d exp %0d", result, display, exp_v); end
      press(K_EQ);
      exp_q.push_back(1000);
      count_busy();
      exp_v = exp_q.pop_front();
      n_cmp++; if (bcnt != W || result !== W'(exp_v))
         begin n_err++; $display("FAIL b2b_repeat: got res=%0d cycles=%0d exp %0d/%0d", result, bcnt, exp_v, W); end
   endtask

   task automatic test_clear_async();
      press(K_CLR);
      press(dig[1]); press(dig[0]); press(dig[0]); press(K_DIV); press(dig[7]); press(K_EQ);
      repeat (5) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL async_pre_busy: got %b exp 1", busy); end
      #2 clear = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || error !== 1'b0 || display !== 16'd0 || result !== 16'd0 || op_pending !== 3'd0 || err_code !== 2'd0)
         begin n_err++; $display("FAIL async_clear: got busy=%b err=%b disp=%0d res=%0d op=%0d exp all 0",
                                 busy, error, display, result, op_pending); end
      @(negedge clk);
      clear = 1'b0;
      press(dig[4]);
      n_cmp++; if (display !== 16'd4) begin n_err++; $display("FAIL async_idle: got %0d exp 4", display); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_div();
      test_div_zero();
      test_overflow();
      test_chain();
      test_keys();
      test_back_to_back();
      test_clear_async();
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
